// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared types and port-index constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned PORT0     = 0;
    localparam int unsigned PORT1     = 1;
    localparam int unsigned NUM_PORTS = 2;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_select.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_select
// Brief    : Combinational winner selection for the two-port data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arb_select
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned WAIT_W    = 3,
    parameter int unsigned BURST_W   = 4
) (
    input  arb_state_e           state_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [WAIT_W-1:0]    wait_cnt_i,
    input  logic [BURST_W-1:0]   burst_cnt_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 hold_o
);

    logic w_cap;
    logic w_rel0;
    logic w_rel1;
    logic w_hold0;
    logic w_hold1;

    // A full burst budget only matters when the other port is waiting.
    assign w_cap   = (burst_cnt_i >= BURST_W'(MAX_BURST));
    assign w_rel0  = (state_i == ST_OWN0) && req_i[PORT0] && req_i[PORT1] && w_cap;
    assign w_rel1  = (state_i == ST_OWN1) && req_i[PORT1] && req_i[PORT0] && w_cap;
    assign w_hold0 = (state_i == ST_OWN0) && req_i[PORT0] && !w_rel0;
    assign w_hold1 = (state_i == ST_OWN1) && req_i[PORT1] && !w_rel1;
    assign hold_o  = w_hold0 | w_hold1;

    always_comb begin
        gnt_o = '0;
        if (w_hold0) begin
            gnt_o[PORT0] = 1'b1;
        end else if (w_hold1) begin
            gnt_o[PORT1] = 1'b1;
        end else if (w_rel0) begin
            gnt_o[PORT1] = 1'b1;
        end else if (w_rel1) begin
            gnt_o[PORT0] = 1'b1;
        end else if (req_i[PORT1] && (wait_cnt_i == WAIT_W'(MAX_WAIT))) begin
            gnt_o[PORT1] = 1'b1;
        end else if (req_i[PORT0]) begin
            gnt_o[PORT0] = 1'b1;
        end else if (req_i[PORT1]) begin
            gnt_o[PORT1] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares a single-port synchronous data RAM between the core (port 0)
//            and a loader/debug master (port 1) with aging and burst lock.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_0_i,
    input  logic              we_0_i,
    input  logic              lock_0_i,
    input  logic [ADDR_W-1:0] addr_0_i,
    input  logic [DATA_W-1:0] wdata_0_i,
    input  logic              req_1_i,
    input  logic              we_1_i,
    input  logic              lock_1_i,
    input  logic [ADDR_W-1:0] addr_1_i,
    input  logic [DATA_W-1:0] wdata_1_i,
    output logic              gnt_0_o,
    output logic              gnt_1_o,
    output logic              rvalid_0_o,
    output logic              rvalid_1_o,
    output logic [DATA_W-1:0] rdata_0_o,
    output logic [DATA_W-1:0] rdata_1_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    arb_state_e             state_q;
    arb_state_e             state_d;
    logic [WAIT_W-1:0]      wait_cnt_q;
    logic [WAIT_W-1:0]      wait_cnt_d;
    logic [BURST_W-1:0]     burst_cnt_q;
    logic [BURST_W-1:0]     burst_cnt_d;
    logic [NUM_PORTS-1:0]   rvalid_q;
    logic [NUM_PORTS-1:0]   rvalid_d;

    logic [NUM_PORTS-1:0]   w_sel_gnt;
    logic [NUM_PORTS-1:0]   w_gnt;
    logic                   w_hold;

    dmem_arb_select #(
        .MAX_WAIT  (MAX_WAIT),
        .MAX_BURST (MAX_BURST),
        .WAIT_W    (WAIT_W),
        .BURST_W   (BURST_W)
    ) u_select (
        .state_i     (state_q),
        .req_i       ({req_1_i, req_0_i}),
        .wait_cnt_i  (wait_cnt_q),
        .burst_cnt_i (burst_cnt_q),
        .gnt_o       (w_sel_gnt),
        .hold_o      (w_hold)
    );

    // Grants are forced low while reset is asserted so the RAM sees no strobes.
    assign w_gnt   = w_sel_gnt & {NUM_PORTS{rst_n}};
    assign gnt_0_o = w_gnt[PORT0];
    assign gnt_1_o = w_gnt[PORT1];

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        if (w_gnt[PORT0]) begin
            mem_addr_o  = addr_0_i;
            mem_wdata_o = wdata_0_i;
            mem_we_o    = we_0_i;
            mem_re_o    = !we_0_i;
        end else if (w_gnt[PORT1]) begin
            mem_addr_o  = addr_1_i;
            mem_wdata_o = wdata_1_i;
            mem_we_o    = we_1_i;
            mem_re_o    = !we_1_i;
        end
    end

    // Burst count grows only while the other port is waiting; a fresh lock restarts it.
    always_comb begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
        if (w_gnt[PORT0] && lock_0_i) begin
            state_d     = ST_OWN0;
            burst_cnt_d = (w_hold ? burst_cnt_q : '0) + BURST_W'(req_1_i);
        end else if (w_gnt[PORT1] && lock_1_i) begin
            state_d     = ST_OWN1;
            burst_cnt_d = (w_hold ? burst_cnt_q : '0) + BURST_W'(req_0_i);
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req_1_i || w_gnt[PORT1]) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    assign rvalid_d = w_gnt & ~{we_1_i, we_0_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign rvalid_0_o = rvalid_q[PORT0];
    assign rvalid_1_o = rvalid_q[PORT1];
    assign rdata_0_o  = rvalid_q[PORT0] ? mem_rdata_i : '0;
    assign rdata_1_o  = rvalid_q[PORT1] ? mem_rdata_i : '0;

endmodule
`default_nettype wire
